// File: rtl/da_dac_if.sv
// Code-write handshake between a requester and the DAC pad driver.
interface da_dac_if #(
  parameter int DW = 8
);
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;

  modport master (output wr_valid, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/da_dac.sv
// DAC pad driver: accepts a code, drives ana_out/ana_override, reports done after settle.
// Optional feature macro DA_DAC_RAMP_EN: ana_out ramps +/-1 per cycle toward the code in LOAD.
//
// state  | meaning
// IDLE   | pad released, waiting for a code
// LOAD   | driving the latched code onto ana_out (ramping when DA_DAC_RAMP_EN)
// SETTLE | code on the pad, counting settle cycles down to zero
// HOLD   | settled, value held, a new code may be accepted
module da_dac #(
  parameter int DW         = 8,
  parameter int SETTLE_CYC = 4,
  parameter int PAD_IDX    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          dacenable,
  da_dac_if.slave       wr,
  output logic [DW-1:0] ana_out,
  output logic          ana_override,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(SETTLE_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE_CYC - 1);

  if (SETTLE_CYC < 1 || PAD_IDX < 0) begin : g_param_check
    $error("da_dac: SETTLE_CYC must be >= 1 and PAD_IDX non-negative");
  end

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SETTLE, S_HOLD} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] target_q, target_d;
  logic [DW-1:0] ana_d;
  logic          ovr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_d;
  logic          live_q;
  logic          accept;
`ifdef DA_DAC_RAMP_EN
  logic [DW-1:0] ramp_nxt;
`endif

  // live_q keeps wr_ready low while reset is asserted, even though IDLE would otherwise allow it
  assign wr.wr_ready = dacenable & live_q & (state_q == S_IDLE || state_q == S_HOLD);
  assign accept      = wr.wr_valid & wr.wr_ready;
  assign busy        = (state_q == S_LOAD) || (state_q == S_SETTLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      ana_out      <= '0;
      ana_override <= 1'b0;
      cnt_q        <= '0;
      done         <= 1'b0;
      live_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      ana_out      <= ana_d;
      ana_override <= ovr_d;
      cnt_q        <= cnt_d;
      done         <= done_d;
      live_q       <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    ana_d    = ana_out;
    ovr_d    = ana_override;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
`ifdef DA_DAC_RAMP_EN
    ramp_nxt = ana_out;
`endif
    if (!dacenable) begin
      // disable aborts any conversion; no done pulse escapes
      state_d = S_IDLE;
      ana_d   = '0;
      ovr_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ovr_d = 1'b0;
          if (accept) begin
            target_d = wr.wr_data;
            state_d  = S_LOAD;
          end
        end
        S_LOAD: begin
          ovr_d = 1'b1;
`ifdef DA_DAC_RAMP_EN
          if (ana_out == target_q) begin
            cnt_d   = CNT_LOAD;
            state_d = S_SETTLE;
          end else begin
            ramp_nxt = (ana_out < target_q) ? ana_out + DW'(1) : ana_out - DW'(1);
            ana_d    = ramp_nxt;
            // settle count starts on the edge the ramp lands on the target
            if (ramp_nxt == target_q) begin
              cnt_d   = CNT_LOAD;
              state_d = S_SETTLE;
            end
          end
`else
          ana_d   = target_q;
          cnt_d   = CNT_LOAD;
          state_d = S_SETTLE;
`endif
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            done_d  = 1'b1;
            state_d = S_HOLD;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        S_HOLD: begin
          if (accept) begin
            target_d = wr.wr_data;
            state_d  = S_LOAD;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_da_dac.sv
// Directed bench for da_dac: per-cycle vector table plus hand-written reset and ramp sequences.
module tb_da_dac;

  logic clk = 1'b0;
  logic rst;
  logic dacenable;
  logic [7:0] ana_out;
  logic ana_override, busy, done;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  da_dac_if #(.DW(8)) bus ();

  da_dac #(.DW(8), .SETTLE_CYC(4), .PAD_IDX(3)) dut (
    .clk(clk), .rst(rst), .dacenable(dacenable), .wr(bus.slave),
    .ana_out(ana_out), .ana_override(ana_override), .busy(busy), .done(done)
  );

  typedef struct {
    logic       en;
    logic       v;
    logic [7:0] d;
    logic       rdy;
    logic [7:0] ana;
    logic       ovr;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int n, input logic en, input logic v, input logic [7:0] d,
                     input logic rdy, input logic [7:0] ana, input logic ovr,
                     input logic bsy, input logic dn);
    vec_t e;
    e = '{en, v, d, rdy, ana, ovr, bsy, dn};
    for (int k = 0; k < n; k++) tbl.push_back(e);
  endtask

  task automatic chk(input string nm, input int step, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h want=%0h", nm, step, got, exp);
    end
  endtask

  task automatic chk_all(input int step, input logic rdy, input logic [7:0] ana,
                         input logic ovr, input logic bsy, input logic dn);
    chk("wr_ready", step, 32'(bus.wr_ready), 32'(rdy));
    chk("ana_out", step, 32'(ana_out), 32'(ana));
    chk("ana_override", step, 32'(ana_override), 32'(ovr));
    chk("busy", step, 32'(busy), 32'(bsy));
    chk("done", step, 32'(done), 32'(dn));
  endtask

  initial begin
    rst = 1'b0;
    dacenable = 1'b1;
    bus.wr_valid = 1'b0;
    bus.wr_data = 8'h00;
    #2;
    chk_all(-1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk_all(-2, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);

`ifndef DA_DAC_RAMP_EN
    //  n  en v  d      rdy ana    ovr bsy dn
    add(1, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
    add(1, 1, 1, 8'hA5, 1, 8'h00, 0, 0, 0);
    add(1, 1, 0, 8'h00, 0, 8'h00, 0, 1, 0);
    add(4, 1, 0, 8'h00, 0, 8'hA5, 1, 1, 0);
    add(1, 1, 0, 8'h00, 1, 8'hA5, 1, 0, 1);
    add(1, 1, 0, 8'h00, 1, 8'hA5, 1, 0, 0);
    add(1, 1, 1, 8'h10, 1, 8'hA5, 1, 0, 0);
    add(1, 1, 1, 8'h20, 0, 8'hA5, 1, 1, 0);
    add(4, 1, 1, 8'h20, 0, 8'h10, 1, 1, 0);
    add(1, 1, 1, 8'h20, 1, 8'h10, 1, 0, 1);
    add(1, 1, 0, 8'h00, 0, 8'h10, 1, 1, 0);
    add(4, 1, 0, 8'h00, 0, 8'h20, 1, 1, 0);
    add(1, 1, 0, 8'h00, 1, 8'h20, 1, 0, 1);
    add(1, 1, 1, 8'h44, 1, 8'h20, 1, 0, 0);
    add(1, 1, 0, 8'h00, 0, 8'h20, 1, 1, 0);
    add(4, 1, 1, 8'h33, 0, 8'h44, 1, 1, 0);
    add(1, 1, 1, 8'h33, 1, 8'h44, 1, 0, 1);
    add(1, 1, 0, 8'h00, 0, 8'h44, 1, 1, 0);
    add(4, 1, 0, 8'h00, 0, 8'h33, 1, 1, 0);
    add(1, 1, 0, 8'h00, 1, 8'h33, 1, 0, 1);
    add(1, 1, 1, 8'h5A, 1, 8'h33, 1, 0, 0);
    add(1, 1, 0, 8'h00, 0, 8'h33, 1, 1, 0);
    add(2, 1, 0, 8'h00, 0, 8'h5A, 1, 1, 0);
    add(1, 0, 0, 8'h00, 0, 8'h5A, 1, 1, 0);
    add(2, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);
    add(6, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);
    add(1, 0, 1, 8'h77, 0, 8'h00, 0, 0, 0);
    add(2, 1, 0, 8'h00, 1, 8'h00, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      dacenable    = tbl[i].en;
      bus.wr_valid = tbl[i].v;
      bus.wr_data  = tbl[i].d;
      #1;
      chk_all(i, tbl[i].rdy, tbl[i].ana, tbl[i].ovr, tbl[i].bsy, tbl[i].dn);
    end
`endif

    // reset in the middle of a conversion, then confirm no late done pulse
    @(negedge clk);
    dacenable = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data = 8'h02;
    #1;
    chk("rst_seq_accept", 100, 32'(bus.wr_ready), 32'd1);
    @(negedge clk);
    bus.wr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_seq_busy", 101, 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    chk_all(102, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      chk_all(103 + i, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    end

`ifdef DA_DAC_RAMP_EN
    begin
      logic [7:0] exp_ana [7];
      logic       exp_bsy [7];
      logic       exp_dn  [7];
      exp_ana = '{8'h01, 8'h02, 8'h03, 8'h03, 8'h03, 8'h03, 8'h03};
      exp_bsy = '{1, 1, 1, 1, 1, 1, 0};
      exp_dn  = '{0, 0, 0, 0, 0, 0, 1};
      @(negedge clk);
      bus.wr_valid = 1'b1;
      bus.wr_data = 8'h03;
      #1;
      chk_all(200, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      bus.wr_valid = 1'b0;
      #1;
      chk_all(201, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) begin
        @(negedge clk);
        #1;
        chk_all(202 + i, exp_dn[i], exp_ana[i], 1'b1, exp_bsy[i], exp_dn[i]);
      end
      @(negedge clk);
      #1;
      chk_all(209, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
